// File: rtl/fp_add_align.sv
// rtl/fp_add_align.sv - FP adder front end: unpack, exponent order, sticky right-align
// Two-stage valid/ready pipeline; stage 1 orders operands, stage 2 aligns the smaller one.
module fp_add_align #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int BIAS      = 127
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]     opX,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]     opY,
  input  logic                             op_sub,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIG_WIDTH*2+2:0]           aSig,
  output logic [SIG_WIDTH*2+2:0]           bSig,
  output logic                             aSign,
  output logic                             eop,
  output logic [EXP_WIDTH-1:0]             exp_out,
  output logic                             swapped,
  output logic                             nan_flag,
  output logic                             inf_flag
);
  localparam int W  = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int MW = SIG_WIDTH + 1;
  localparam int XW = 2 * SIG_WIDTH + 3;
  // Biased exponent of the smallest normal (1 - BIAS unbiased); zero/denormals use it.
  localparam logic [EXP_WIDTH-1:0] DENORM_EXP = EXP_WIDTH'(BIAS + (1 - BIAS));

  logic                 s1_valid_q, s1_valid_d;
  logic [MW-1:0]        s1_a_sig_q, s1_a_sig_d, s1_b_sig_q, s1_b_sig_d;
  logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d, s1_diff_q, s1_diff_d;
  logic                 s1_sign_q, s1_sign_d, s1_eop_q, s1_eop_d;
  logic                 s1_swap_q, s1_swap_d, s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;

  logic                 out_valid_q, out_valid_d;
  logic [XW-1:0]        asig_q, asig_d, bsig_q, bsig_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d, eop_q, eop_d, swap_q, swap_d;
  logic                 nan_q, nan_d, inf_q, inf_d;

  logic [EXP_WIDTH-1:0] ex_x, ex_y, eff_x, eff_y;
  logic [SIG_WIDTH-1:0] fr_x, fr_y;
  logic [MW-1:0]        sig_x, sig_y;
  logic                 sign_x, sign_y, swap, eop_now;
  logic                 nan_x, nan_y, inf_x, inf_y, nan_now;
  logic                 s2_adv;
  logic [31:0]          sh;
  logic [XW-1:0]        b_ext;
  logic [2*XW-1:0]      sh_cat;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_comb begin
    ex_x    = opX[W-2:SIG_WIDTH];
    ex_y    = opY[W-2:SIG_WIDTH];
    fr_x    = opX[SIG_WIDTH-1:0];
    fr_y    = opY[SIG_WIDTH-1:0];
    eff_x   = (ex_x == '0) ? DENORM_EXP : ex_x;
    eff_y   = (ex_y == '0) ? DENORM_EXP : ex_y;
    sig_x   = {|ex_x, fr_x};
    sig_y   = {|ex_y, fr_y};
    sign_x  = opX[W-1];
    sign_y  = opY[W-1] ^ op_sub;
    swap    = eff_y > eff_x;
    eop_now = sign_x ^ sign_y;
    nan_x   = (&ex_x) && (fr_x != '0);
    nan_y   = (&ex_y) && (fr_y != '0);
    inf_x   = (&ex_x) && (fr_x == '0);
    inf_y   = (&ex_y) && (fr_y == '0);
    nan_now = nan_x || nan_y || (inf_x && inf_y && eop_now);
  end

  // Shifting b through a double-width window leaves the shifted-out bits in the low half.
  always_comb begin
    sh     = (32'(s1_diff_q) > 32'(XW - 1)) ? 32'(XW - 1) : 32'(s1_diff_q);
    b_ext  = {1'b0, s1_b_sig_q, {MW{1'b0}}};
    sh_cat = {b_ext, {XW{1'b0}}} >> sh;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_sig_d  = s1_a_sig_q;
    s1_b_sig_d  = s1_b_sig_q;
    s1_exp_d    = s1_exp_q;
    s1_diff_d   = s1_diff_q;
    s1_sign_d   = s1_sign_q;
    s1_eop_d    = s1_eop_q;
    s1_swap_d   = s1_swap_q;
    s1_nan_d    = s1_nan_q;
    s1_inf_d    = s1_inf_q;
    out_valid_d = out_valid_q;
    asig_d      = asig_q;
    bsig_d      = bsig_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    eop_d       = eop_q;
    swap_d      = swap_q;
    nan_d       = nan_q;
    inf_d       = inf_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_sig_d = swap ? sig_y : sig_x;
        s1_b_sig_d = swap ? sig_x : sig_y;
        s1_exp_d   = swap ? eff_y : eff_x;
        s1_diff_d  = swap ? (eff_y - eff_x) : (eff_x - eff_y);
        s1_sign_d  = swap ? sign_y : sign_x;
        s1_eop_d   = eop_now;
        s1_swap_d  = swap;
        s1_nan_d   = nan_now;
        s1_inf_d   = (inf_x || inf_y) && !nan_now;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        asig_d = {1'b0, s1_a_sig_q, {MW{1'b0}}};
        bsig_d = {sh_cat[2*XW-1:XW+1], sh_cat[XW] | (|sh_cat[XW-1:0])};
        exp_d  = s1_exp_q;
        sign_d = s1_sign_q;
        eop_d  = s1_eop_q;
        swap_d = s1_swap_q;
        nan_d  = s1_nan_q;
        inf_d  = s1_inf_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_sig_q  <= '0;
      s1_b_sig_q  <= '0;
      s1_exp_q    <= '0;
      s1_diff_q   <= '0;
      s1_sign_q   <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_swap_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      asig_q      <= '0;
      bsig_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      eop_q       <= 1'b0;
      swap_q      <= 1'b0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_sig_q  <= s1_a_sig_d;
      s1_b_sig_q  <= s1_b_sig_d;
      s1_exp_q    <= s1_exp_d;
      s1_diff_q   <= s1_diff_d;
      s1_sign_q   <= s1_sign_d;
      s1_eop_q    <= s1_eop_d;
      s1_swap_q   <= s1_swap_d;
      s1_nan_q    <= s1_nan_d;
      s1_inf_q    <= s1_inf_d;
      out_valid_q <= out_valid_d;
      asig_q      <= asig_d;
      bsig_q      <= bsig_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      eop_q       <= eop_d;
      swap_q      <= swap_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign aSig      = asig_q;
  assign bSig      = bsig_q;
  assign aSign     = sign_q;
  assign eop       = eop_q;
  assign exp_out   = exp_q;
  assign swapped   = swap_q;
  assign nan_flag  = nan_q;
  assign inf_flag  = inf_q;
endmodule

// File: tb/tb_fp_add_align.sv
// tb/tb_fp_add_align.sv - self-checking bench for fp_add_align
// Reference model computes each result from the operand values; a negedge monitor scores every output.
module tb_fp_add_align;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] opX, opY;
  logic [48:0] aSig, bSig;
  logic        aSign, eop, swapped, nan_flag, inf_flag;
  logic [7:0]  exp_out;
  logic [110:0] dut_out, held;
  logic        prev_stall = 1'b0;
  logic [110:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  fp_add_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opX(opX), .opY(opY), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .aSig(aSig), .bSig(bSig), .aSign(aSign), .eop(eop), .exp_out(exp_out),
    .swapped(swapped), .nan_flag(nan_flag), .inf_flag(inf_flag)
  );

  always #5 clk = ~clk;
  assign dut_out = {aSig, bSig, aSign, eop, exp_out, swapped, nan_flag, inf_flag};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Value-level reference: real significands, plain shifts, sticky = any lost bit.
  function automatic logic [110:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic [63:0] ex, ey, mx, my, ea, eb, ma, mb, a49, b49, bs;
    logic sx, sy, sa, sw, nanv, infv, xinf, yinf;
    int d;
    xinf = (x[30:0] == 31'h7F800000);
    yinf = (y[30:0] == 31'h7F800000);
    sx = x[31];
    sy = y[31] ^ sub;
    nanv = (x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0) ||
           (xinf && yinf && (sx ^ sy));
    infv = !nanv && (xinf || yinf);
    ex = {56'b0, x[30:23]};
    ey = {56'b0, y[30:23]};
    mx = (ex != 0) ? {40'b0, 1'b1, x[22:0]} : {40'b0, 1'b0, x[22:0]};
    my = (ey != 0) ? {40'b0, 1'b1, y[22:0]} : {40'b0, 1'b0, y[22:0]};
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    sw = ey > ex;
    if (sw) begin ea = ey; eb = ex; ma = my; mb = mx; sa = sy; end
    else    begin ea = ex; eb = ey; ma = mx; mb = my; sa = sx; end
    d = int'(ea - eb);
    a49 = ma << 24;
    b49 = mb << 24;
    if (d >= 48) bs = (b49 != 0) ? 64'd1 : 64'd0;
    else begin
      bs = b49 >> d;
      if ((bs << d) != b49) bs = bs | 64'd1;
    end
    return {a49[48:0], bs[48:0], sa, sx ^ sy, ea[7:0], sw, nanv, infv};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold", {out_valid, dut_out}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious: got out_valid=1 required no pending result");
        end else check("result", dut_out, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(opX, opY, op_sub));
      prev_stall = out_valid && !out_ready;
      held = dut_out;
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
    int t;
    opX = x; opY = y; op_sub = s; in_valid = 1'b1; t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin t++; @(negedge clk); end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 100 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin t++; @(negedge clk); end
    check("drain_pending", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] vx [12] = '{32'h3F800000, 32'h3F000000, 32'h4B800000, 32'h5D800000, 32'h5D800000, 32'h7F800000,
                           32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h00000001, 32'h40490FDB, 32'hC0000000};
  logic [31:0] vy [12] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'hFF800000,
                           32'h12345678, 32'h3F800000, 32'h3F800000, 32'h00000003, 32'h3DCCCCCD, 32'h4B000001};
  logic        vs [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opX = '0; opY = '0; op_sub = 1'b0;

    check("pin_one_plus_one", model(32'h3F800000, 32'h3F800000, 1'b0),
          {49'h800000000000, 49'h800000000000, 1'b0, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0});
    check("pin_half_minus_one", model(32'h3F000000, 32'hBF800000, 1'b0),
          {49'h800000000000, 49'h400000000000, 1'b1, 1'b1, 8'd127, 1'b1, 1'b0, 1'b0});
    check("pin_shift24", model(32'h4B800000, 32'h3F800000, 1'b0),
          {49'h800000000000, 49'h000000800000, 1'b0, 1'b0, 8'd151, 1'b0, 1'b0, 1'b0});
    check("pin_sticky_only", model(32'h5D800000, 32'h3F800000, 1'b0),
          {49'h800000000000, 49'h1, 1'b0, 1'b0, 8'd187, 1'b0, 1'b0, 1'b0});
    check("pin_far_zero", model(32'h5D800000, 32'h00000000, 1'b0),
          {49'h800000000000, 49'h0, 1'b0, 1'b0, 8'd187, 1'b0, 1'b0, 1'b0});
    check("pin_inf_minus_inf", model(32'h7F800000, 32'hFF800000, 1'b0),
          {49'h800000000000, 49'h800000000000, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1, 1'b0});
    check("pin_inf_plus_one", model(32'h7F800000, 32'h3F800000, 1'b0),
          {49'h800000000000, 49'h1, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {out_valid, in_ready, dut_out}, {1'b0, 1'b1, 111'b0});
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) send(vx[i], vy[i], vs[i]);
    drain();

    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'h40000000, 1'b0);
        send(32'h40400000, 32'hC0800000, 1'b1);
        send(32'h41200000, 32'h3C23D70A, 1'b0);
        send(32'h00400000, 32'h80200000, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_stalled", {126'b0, out_valid, in_ready}, {126'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    fork
      for (int i = 0; i < 12; i++) send(vy[i], vx[11 - i], vs[i] ^ 1'b1);
      begin
        repeat (40) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0);
    send(32'h5D800000, 32'h3F800000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_flush", {out_valid, in_ready, dut_out}, {1'b0, 1'b1, 111'b0});
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_idle", {127'b0, out_valid}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_add_align.md
Name: fp_add_align

Overview:
- Operand-preparation front end of the single-precision FP adder.
- Takes two IEEE-754 binary32 operands and an add/sub opcode, then unpacks them, orders them by exponent and computes the effective operation.
- Right-aligns the smaller-exponent significand with sticky collection.
- Drives the extended-significand/sign/eop interface consumed by the end-around-carry adder stage, as a 2-stage valid/ready pipeline.

Parameters:
- SIG_WIDTH, 23: stored fraction width.
- EXP_WIDTH, 8: exponent width.
- BIAS, 127: exponent bias, used only for the zero/denormal effective-exponent rule.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage 1 can accept this cycle.
- opX  input  SIG_WIDTH+EXP_WIDTH+1  first operand, binary32.
- opY  input  SIG_WIDTH+EXP_WIDTH+1  second operand, binary32.
- op_sub  input  1  1 = X-Y, 0 = X+Y.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts.
- aSig  output  SIG_WIDTH*2+3  larger-exponent significand, unshifted.
- bSig  output  SIG_WIDTH*2+3  smaller-exponent significand, aligned, sticky in bit 0.
- aSign  output  1  sign of the aSig operand.
- eop  output  1  effective subtraction.
- exp_out  output  EXP_WIDTH  common (larger) exponent.
- swapped  output  1  1 = aSig came from opY.
- nan_flag  output  1  either operand is NaN, or Inf-Inf under eop.
- inf_flag  output  1  result is infinite (not NaN).

Behaviour:
- Reset: every output register clears to 0, both stage valids clear, and in_ready=1 the cycle after rst falls. A rst held mid-operation discards all in-flight entries; nothing is emitted.
- Unpack:
  - Hidden bit = (exp!=0).
  - Effective exponent = exp, or 1 when exp==0 (denormal/zero).
  - Y sign is inverted when op_sub=1.
- Extended significand layout (49 bits at default):
  - bit [2*SIG_WIDTH+2] = carry headroom, always 0.
  - bits [2*SIG_WIDTH+1 : SIG_WIDTH+1] = hidden bit and fraction.
  - low SIG_WIDTH+1 bits = 0 before alignment.
- Stage 1, registered on accept:
  - Compare effective exponents. The larger becomes a; on equality X becomes a (swapped=0).
  - eop = signX ^ signY_eff.
  - diff = expA-expB.
  - Special-value flags computed here.
- Stage 2, registered:
  - bSig = b significand >> min(diff, 2*SIG_WIDTH+2).
  - OR of all bits shifted out is ORed into bit 0.
  - Any diff >= 2*SIG_WIDTH+2 yields bSig = 1 if b is nonzero, else 0.
  - aSig passes unshifted.
  - exp_out = expA.
- Arithmetic is unsigned throughout; diff is EXP_WIDTH bits and never negative after the swap.
- Latency: 2 cycles from accept (in_valid & in_ready) to out_valid with no stall.
- Handshake:
  - Stage 2 advances when !out_valid or out_ready.
  - Stage 1 advances into stage 2 when stage 2 advances.
  - in_ready = !s1_valid | s1_advance (combinational from out_ready; no skid buffer).
  - Outputs hold stable while out_valid & !out_ready.
  - Order is preserved and there is no drop or duplication.
  - Accept and emit in the same cycle are legal and give full throughput of 1/cycle.
- Special values:
  - nan_flag=1 if either operand has exp all-ones with fraction!=0, or both are Inf with eop=1.
  - inf_flag=1 if any operand is Inf and nan_flag=0.
  - Sig/sign/exp datapath outputs still follow the normal rules; downstream selects on the flags.

Test Plan:
- X=0x3F800000, Y=0x3F800000, op_sub=0 -> after 2 cycles: aSig=bSig=2^47, eop=0, aSign=0, exp_out=127, swapped=0.
- X=0x3F000000 (0.5), Y=0xBF800000 (-1.0), op_sub=0 -> swapped=1, aSig=2^47, bSig=2^46, aSign=1, eop=1, exp_out=127.
- Shift boundary:
  - X=0x4B800000 (2^24), Y=0x3F800000 -> bSig=2^23.
  - X=0x5D800000 (2^60), Y=0x3F800000 -> bSig=1 (sticky only), exp_out=187.
  - X=0x5D800000, Y=0x00000000 -> bSig=0.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, outputs held stable; after release all 4 emerge in order, none lost.
- Special values:
  - X=0x7F800000, Y=0xFF800000, op_sub=0 -> nan_flag=1, inf_flag=0.
  - X=0x7FC00000, Y=any -> nan_flag=1.
  - X=0x7F800000, Y=0x3F800000 -> inf_flag=1.
- Reset: rst asserted for 1 cycle with 2 entries in flight -> next cycle out_valid=0, in_ready=1, all outputs 0; no stale result emitted.
